sne_evt_packetizer: RTL

- Transmit-side mUDP framer: buffers a stream of 32-bit uevents, then emits one mUDP packet per group: header word, then the buffered events as payload.
- Sits between the engine/event output and the bus/stream fabric. It is the counterpart of the header-driven redirection logic that consumes mUDP_header_t.
- Packet close triggers: length limit, an in-band EVT_PKT_END event, idle timeout, or disable.

---
 rtl/sne_evt_packetizer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sne_evt_packetizer.sv
// Transmit-side mUDP framer: buffers 32-bit uevents and emits header + payload packets.
// Optional macro SNE_PKT_EOP_TAIL_EN appends an EOP tail word after the payload.
module sne_evt_packetizer #(
  parameter int          FIFO_DEPTH     = 16,
  parameter int          MAX_LEN        = 16,
  parameter logic [3:0]  HDR_OPTION     = 4'hA,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic [3:0]  cfg_gdst_i,
  input  logic [7:0]  cfg_ldst_i,
  input  logic        evt_valid_i,
  output logic        evt_ready_o,
  input  logic [31:0] evt_data_i,
  output logic        pkt_valid_o,
  input  logic        pkt_ready_i,
  output logic [31:0] pkt_data_o,
  output logic        pkt_last_o,
  output logic        busy_o,
  output logic        pkt_sent_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [3:0] OP_PKT_END = 4'h6;

`ifdef SNE_PKT_EOP_TAIL_EN
  localparam bit PAYLOAD_LAST = 1'b0;
`else
  localparam bit PAYLOAD_LAST = 1'b1;
`endif

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    HEADER,
    PAYLOAD
`ifdef SNE_PKT_EOP_TAIL_EN
    , TAIL
`endif
  } state_t;

  state_t        state;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] len, rem;
  logic [TW-1:0] tcnt;

  logic          evt_fire, is_end, store, close, timeout_hit, pkt_xfer;
  logic [LW-1:0] len_next;

  assign evt_ready_o = rst_ni && enable_i && (state == IDLE || state == COLLECT)
                       && (len < LW'(MAX_LEN));
  assign evt_fire    = evt_valid_i && evt_ready_o;
  assign is_end      = (evt_data_i[31:28] == OP_PKT_END);
  assign store       = evt_fire && !is_end;
  assign len_next    = store ? len + 1'b1 : len;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == COLLECT) && !evt_fire && (tcnt == T_LAST);
  // A PKT_END arriving with an empty buffer is swallowed without producing a packet.
  assign close       = (store && len == LW'(MAX_LEN - 1))
                    || (evt_fire && is_end && len != '0)
                    || timeout_hit
                    || (state == COLLECT && !enable_i);

  assign pkt_xfer    = pkt_valid_o && pkt_ready_i;
  assign pkt_sent_o  = pkt_xfer && pkt_last_o;
  assign busy_o      = (state != IDLE);

  // NOTE: payload storage has no reset; the read/write pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (store) mem[wr_ptr] <= evt_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      len         <= '0;
      rem         <= '0;
      tcnt        <= '0;
      pkt_valid_o <= 1'b0;
      pkt_data_o  <= '0;
      pkt_last_o  <= 1'b0;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          if (store) begin
            wr_ptr <= wr_ptr + 1'b1;
            len    <= len_next;
            tcnt   <= '0;
            state  <= COLLECT;
          end else if (state == COLLECT && !evt_fire && tcnt != T_LAST) begin
            tcnt <= tcnt + 1'b1;
          end
          if (close) begin
            state       <= HEADER;
            tcnt        <= '0;
            pkt_valid_o <= 1'b1;
            pkt_data_o  <= {HDR_OPTION, cfg_gdst_i, cfg_ldst_i, 16'(len_next)};
            pkt_last_o  <= 1'b0;
          end
        end

        HEADER: begin
          if (pkt_xfer) begin
            state      <= PAYLOAD;
            pkt_data_o <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 1'b1;
            rem        <= len - 1'b1;
            pkt_last_o <= PAYLOAD_LAST && (len == LW'(1));
          end
        end

        PAYLOAD: begin
          if (pkt_xfer) begin
            if (rem == '0) begin
`ifdef SNE_PKT_EOP_TAIL_EN
              state      <= TAIL;
              pkt_data_o <= {4'h9, 28'h0};
              pkt_last_o <= 1'b1;
`else
              state       <= IDLE;
              pkt_valid_o <= 1'b0;
              pkt_last_o  <= 1'b0;
              len         <= '0;
`endif
            end else begin
              pkt_data_o <= mem[rd_ptr];
              rd_ptr     <= rd_ptr + 1'b1;
              rem        <= rem - 1'b1;
              pkt_last_o <= PAYLOAD_LAST && (rem == LW'(1));
            end
          end
        end

`ifdef SNE_PKT_EOP_TAIL_EN
        TAIL: begin
          if (pkt_xfer) begin
            state       <= IDLE;
            pkt_valid_o <= 1'b0;
            pkt_last_o  <= 1'b0;
            len         <= '0;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule
